// File: rtl/fnv1a_hash_ctrl.sv
// FNV-1a 32-bit byte-serial hash controller.
// Each accepted byte is folded in with a 6-cycle shift-and-add multiply by the FNV prime.
module fnv1a_hash_ctrl #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
  parameter int unsigned COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [31:0]        hash_out,
  output logic               hash_valid,
  output logic               busy,
  output logic [COUNT_W-1:0] byte_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [31:0]        hash_q;
  logic [31:0]        acc_q;
  logic [31:0]        x_q;
  logic [2:0]         step_q;
  logic               last_q;
  logic               busy_q;
  logic               valid_q;
  logic [COUNT_W-1:0] count_q;

  logic               accept;
  logic [31:0]        term;

  // 16777619 = 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 2^0
  always_comb begin
    term = x_q;
    case (step_q)
      3'd0:    term = x_q;
      3'd1:    term = x_q << 1;
      3'd2:    term = x_q << 4;
      3'd3:    term = x_q << 7;
      3'd4:    term = x_q << 8;
      default: term = x_q << 24;
    endcase
  end

  assign in_ready = rst_n & (state_q == IDLE) & ~clear;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hash_q  <= OFFSET_BASIS;
      acc_q   <= '0;
      x_q     <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      hash_q  <= OFFSET_BASIS;
      acc_q   <= '0;
      x_q     <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q     <= hash_q ^ {24'b0, in_data};
            acc_q   <= '0;
            step_q  <= '0;
            last_q  <= in_last;
            busy_q  <= 1'b1;
            state_q <= MUL;
            if (count_q != {COUNT_W{1'b1}}) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        MUL: begin
          // hash_q only moves on the final term; partial sums stay in acc_q
          if (step_q == 3'd5) begin
            hash_q  <= acc_q + term;
            step_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= last_q;
            state_q <= last_q ? DONE : IDLE;
          end else begin
            acc_q  <= acc_q + term;
            step_q <= step_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign hash_out   = hash_q;
  assign hash_valid = valid_q;
  assign busy       = busy_q;
  assign byte_count = count_q;

endmodule
